// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instruction} entries with occupancy count and flush.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; r_count alone decides validity.
  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr_ptr] <= push_entry;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential imem requests under a credit limit, in-order
// responses buffered toward decode, redirect flushes buffered and in-flight work.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  state_t          w_state_next;
  logic [XLEN-1:0] w_fetch_pc_next;
  logic [XLEN-1:0] w_resp_pc_next;
  logic [CW-1:0]   w_outstanding_next;
  logic [CW-1:0]   w_drop_next;

  logic            w_credit;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_resp_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_inst_valid;
  logic [CW-1:0]   w_fifo_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;

  // Credit counts buffered plus in-flight work so a response always has a slot.
  assign w_credit    = ((CW+1)'(r_outstanding) + (CW+1)'(w_fifo_count)) < (CW+1)'(DEPTH);
  assign w_req_valid = !reset && (r_state == RUN) && w_credit;
  assign w_fire      = w_req_valid && imem_req_ready;

  // A response with nothing in flight cannot belong to us and is ignored.
  assign w_resp_accept = imem_resp_valid && ((r_outstanding != '0) || w_fire);
  assign w_push        = w_resp_accept && (r_state == RUN) && !redirect_valid;
  assign w_push_entry  = '{pc: r_resp_pc, data: imem_resp_data};

  assign w_inst_valid = !reset && (w_fifo_count != '0);
  assign w_pop        = w_inst_valid && inst_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .head       (w_head),
    .count      (w_fifo_count)
  );

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_resp_pc_next     = r_resp_pc;
    w_drop_next        = r_drop;
    w_outstanding_next = r_outstanding + CW'(w_fire) - CW'(w_resp_accept);

    if (w_fire) w_fetch_pc_next = r_fetch_pc + STEP;
    if (w_push) w_resp_pc_next  = r_resp_pc + STEP;

    unique case (r_state)
      RUN: ;
      FLUSH: begin
        if (w_resp_accept) begin
          w_drop_next = r_drop - CW'(1);
          if (r_drop == CW'(1)) w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase

    // Anything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      w_fetch_pc_next = redirect_pc;
      w_resp_pc_next  = redirect_pc;
      w_drop_next     = w_outstanding_next;
      w_state_next    = (w_outstanding_next != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_resp_pc     <= w_resp_pc_next;
      r_outstanding <= w_outstanding_next;
      r_drop        <= w_drop_next;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = reset ? RESET_PC : r_fetch_pc;
  assign inst_valid     = w_inst_valid;
  assign inst_pc        = w_inst_valid ? w_head.pc   : '0;
  assign inst_data      = w_inst_valid ? w_head.data : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory with a
// path-tagged model of the instruction stream, checked every cycle.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data),
    .inst_ready      (inst_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus knobs applied by step() at each negedge.
  logic        s_reset = 1'b1, s_redir = 1'b0, s_ready = 1'b0, s_iready = 1'b0;
  logic [31:0] s_redir_pc = '0;
  int          lat = 0;

  // Model: memory in-flight queue tagged by path epoch, and expected buffer.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;
  mreq_t       mq[$];
  logic [31:0] mbuf[$];
  logic [31:0] m_fetch = RPC;
  int          epoch   = 0;

  // Observations for the directed literal checks.
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_data_log[$];
  logic        o_iv, o_rv;
  logic [31:0] o_ra, o_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
    pop_data_log.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model, play memory, advance model.
  task automatic step();
    int          stale;
    logic        e_rv, e_iv, fire, deliver;
    mreq_t       d;
    @(negedge clock);
    reset           = s_reset;
    redirect_valid  = s_redir;
    redirect_pc     = s_redir_pc;
    imem_req_ready  = s_ready;
    inst_ready      = s_iready;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #1;

    stale = 0;
    foreach (mq[i]) if (mq[i].ep != epoch) stale++;
    e_rv = !s_reset && (stale == 0) && ((mq.size() + mbuf.size()) < DEPTH);
    e_iv = !s_reset && (mbuf.size() > 0);
    check("req_valid", imem_req_valid, e_rv);
    if (s_reset || e_rv) check("req_addr", imem_req_addr, s_reset ? RPC : m_fetch);
    check("inst_valid", inst_valid, e_iv);
    check("inst_pc", inst_pc, e_iv ? mbuf[0] : 32'h0);
    check("inst_data", inst_data, e_iv ? mem_word(mbuf[0]) : 32'h0);
    o_iv = inst_valid; o_rv = imem_req_valid; o_ra = imem_req_addr; o_ipc = inst_pc;

    fire = imem_req_valid && s_ready;
    if (fire) mq.push_back('{addr: imem_req_addr, due: cyc + lat, ep: epoch});
    deliver = (mq.size() > 0) && (mq[0].due <= cyc);
    if (deliver) begin
      d = mq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(d.addr);
    end

    if (s_reset) begin
      mq.delete();
      mbuf.delete();
      m_fetch = RPC;
    end else begin
      if (inst_valid && s_iready) begin
        pop_log.push_back(inst_pc);
        pop_data_log.push_back(inst_data);
        if (mbuf.size() > 0) void'(mbuf.pop_front());
      end
      if (fire) begin
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
        m_fetch = m_fetch + 32'd4;
      end
      if (deliver && !s_redir && d.ep == epoch) mbuf.push_back(d.addr);
      if (s_redir) begin
        mbuf.delete();
        epoch++;
        m_fetch = s_redir_pc;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    s_ready = 1'b0; s_redir = 1'b0; s_iready = 1'b1;
    for (int i = 0; i < 20 && (mq.size() != 0 || mbuf.size() != 0); i++) step();
    check("drain_timeout", (mq.size() == 0 && mbuf.size() == 0), 1);
  endtask

  initial begin
    int rc;

    // Reset: outputs pinned during the reset cycle.
    s_reset = 1'b1; s_ready = 1'b1; s_iready = 1'b1;
    step();
    step();
    check("rst_req_valid", o_rv, 0);
    check("rst_req_addr", o_ra, 32'h100);
    check("rst_inst_valid", o_iv, 0);
    check("rst_inst_pc", o_ipc, 0);

    // Streaming with a same-cycle memory: back-to-back requests.
    s_reset = 1'b0; lat = 0;
    clear_logs();
    repeat (8) step();
    check("t1_req0", req_log[0], 32'h100);
    check("t1_req1", req_log[1], 32'h104);
    check("t1_req2", req_log[2], 32'h108);
    check("t1_req_gap01", req_cyc[1] - req_cyc[0], 1);
    check("t1_req_gap12", req_cyc[2] - req_cyc[1], 1);
    check("t1_pop0", pop_log[0], 32'h100);
    check("t1_pop2", pop_log[2], 32'h108);
    check("t1_data1", pop_data_log[1], 32'h5A5A_0104);

    // Decode stall: credit caps requests, nothing lost on release.
    s_iready = 1'b0;
    clear_logs();
    repeat (5) step();
    check("t2_stall_reqs", req_log.size(), 1);
    check("t2_stall_valid_low", o_rv, 0);
    s_iready = 1'b1;
    clear_logs();
    repeat (6) step();
    check("t2_rel_pop0", pop_log[0], 32'h11C);
    check("t2_rel_pop1", pop_log[1], 32'h120);
    check("t2_rel_req0", req_log[0], 32'h124);

    // Two in flight on a 3-cycle memory, then redirect.
    drain();
    lat = 3; s_ready = 1'b1;
    clear_logs();
    step();
    step();
    s_redir = 1'b1; s_redir_pc = 32'h200;
    step();
    rc = cyc - 1;
    s_redir = 1'b0;
    repeat (10) step();
    check("t3_new_req", req_log[2], 32'h200);
    check("t3_new_req_delay", req_cyc[2] - rc, 3);
    check("t3_first_pop", pop_log[0], 32'h200);

    // Redirect coinciding with a response and a request handshake.
    drain();
    lat = 1; s_ready = 1'b1;
    clear_logs();
    step();
    s_redir = 1'b1; s_redir_pc = 32'h300;
    step();
    rc = cyc - 1;
    s_redir = 1'b0;
    step();
    check("t4_buf_empty", o_iv, 0);
    repeat (6) step();
    check("t4_stale_req_cycle", req_cyc[1], rc);
    check("t4_new_req", req_log[2], 32'h300);
    check("t4_new_req_delay", req_cyc[2] - rc, 2);
    check("t4_first_pop", pop_log[0], 32'h300);

    // Address wrap at the top of memory.
    drain();
    lat = 0;
    s_redir = 1'b1; s_redir_pc = 32'hFFFF_FFFC;
    step();
    s_redir = 1'b0; s_ready = 1'b1;
    clear_logs();
    repeat (4) step();
    check("t5_req0", req_log[0], 32'hFFFF_FFFC);
    check("t5_req1", req_log[1], 32'h0000_0000);
    check("t5_pop0", pop_log[0], 32'hFFFF_FFFC);
    check("t5_pop1", pop_log[1], 32'h0000_0000);
    check("t5_data0", pop_data_log[0], 32'hA5A5_FFFC);

    // Reset with a buffered instruction and a request still in flight.
    drain();
    lat = 3; s_ready = 1'b1; s_iready = 1'b0;
    repeat (4) step();
    check("t6_pre_buf", o_iv, 0);
    s_reset = 1'b1;
    step();
    s_reset = 1'b0; s_iready = 1'b1; lat = 0;
    clear_logs();
    step();
    check("t6_inst_valid", o_iv, 0);
    check("t6_req_addr", o_ra, 32'h100);
    check("t6_req_valid", o_rv, 1);
    repeat (4) step();
    check("t6_first_pop", pop_log[0], 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
